fpxx_to_fixed: RTL and testbench

- Pipelined converter from IEEE-754 fp32 to signed fixed-point.
- Sits directly downstream of the fp32 adder. Consumes its 32-bit sum and produces a saturated two's-complement fixed-point word for integer datapaths and debug readout.
- Uses a valid/ready stream on both sides. Throughput is 1 word/cycle and latency is 3 cycles when not stalled.

---
 rtl/fpxx_to_fixed_if.sv | 24 ++
 rtl/fpxx_to_fixed.sv | 205 ++++++++++++++++++++
 tb/tb_fpxx_to_fixed.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fpxx_to_fixed_if.sv
// Valid/ready stream bundle for the fp32 -> fixed-point converter.
// slave is the converter's view, master is the producer/consumer side.
interface fpxx_to_fixed_if #(
    parameter int OUT_WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_ovf;
    logic                 out_nan;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_nan
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_nan
    );
endinterface

// File: rtl/fpxx_to_fixed.sv
// Three-stage fp32 -> saturated signed fixed-point converter (decode, shift, sign/saturate).
// Define FPXX_TO_FIXED_ROUND_EN for round-to-nearest-even; default truncates toward zero.
module fpxx_to_fixed #(
    parameter int OUT_WIDTH = 32,
    parameter int FRAC_BITS = 8
) (
    input  logic           osc_clk,
    input  logic           osc_reset_n,
    fpxx_to_fixed_if.slave bus
);

    localparam logic signed [9:0]  SH_BIAS = 10'(FRAC_BITS - 150);
    localparam logic signed [10:0] LIMIT_E = 11'(OUT_WIDTH - 1);
    localparam logic [OUT_WIDTH-1:0] POS_SAT = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] NEG_SAT = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic rdy_q, rdy_d;
    logic s1_accept, s2_accept, s3_accept, in_fire;

    logic              s1_valid_q, s1_valid_d;
    logic              s1_sign_q, s1_sign_d;
    logic [23:0]       s1_mant_q, s1_mant_d;
    logic signed [9:0] s1_sh_q, s1_sh_d;
    logic              s1_zero_q, s1_zero_d;
    logic              s1_nan_q, s1_nan_d;
    logic              s1_inf_q, s1_inf_d;

    logic                 s2_valid_q, s2_valid_d;
    logic                 s2_sign_q, s2_sign_d;
    logic [OUT_WIDTH-1:0] s2_mag_q, s2_mag_d;
    logic                 s2_ovf_q, s2_ovf_d;
    logic                 s2_zero_q, s2_zero_d;
    logic                 s2_nan_q, s2_nan_d;
    logic signed [10:0]   s2_e;
    logic [9:0]           shr_amt;
`ifdef FPXX_TO_FIXED_ROUND_EN
    logic                 s2_guard_q, s2_guard_d;
    logic                 s2_sticky_q, s2_sticky_d;
    logic [47:0]          shr_ext;
    logic [OUT_WIDTH:0]   rmag;
`endif

    logic                 s3_valid_q, s3_valid_d;
    logic [OUT_WIDTH-1:0] s3_data_q, s3_data_d;
    logic                 s3_ovf_q, s3_ovf_d;
    logic                 s3_nan_q, s3_nan_d;
    logic [OUT_WIDTH-1:0] mag_fin;
    logic                 ovf_fin;

    // A stage accepts when empty or when its contents move on this cycle.
    always_comb begin
        s3_accept = !s3_valid_q || bus.out_ready;
        s2_accept = !s2_valid_q || s3_accept;
        s1_accept = !s1_valid_q || s2_accept;
        in_fire   = bus.in_valid && rdy_q && s1_accept;
        rdy_d     = 1'b1;
    end

    always_comb begin
        s1_valid_d = s1_accept ? in_fire : s1_valid_q;
        s1_sign_d  = s1_sign_q;
        s1_mant_d  = s1_mant_q;
        s1_sh_d    = s1_sh_q;
        s1_zero_d  = s1_zero_q;
        s1_nan_d   = s1_nan_q;
        s1_inf_d   = s1_inf_q;
        if (in_fire) begin
            s1_sign_d = bus.in_data[31];
            s1_mant_d = {1'b1, bus.in_data[22:0]};
            s1_sh_d   = $signed({2'b00, bus.in_data[30:23]}) + SH_BIAS;
            s1_zero_d = (bus.in_data[30:23] == 8'd0);
            s1_nan_d  = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
            s1_inf_d  = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] == 23'd0);
        end
    end

    // Overflow is decided from the exponent alone; the shifted value may wrap when it fires.
    always_comb begin
        s2_valid_d = s2_accept ? s1_valid_q : s2_valid_q;
        s2_sign_d  = s2_sign_q;
        s2_mag_d   = s2_mag_q;
        s2_ovf_d   = s2_ovf_q;
        s2_zero_d  = s2_zero_q;
        s2_nan_d   = s2_nan_q;
        s2_e       = {s1_sh_q[9], s1_sh_q} + 11'sd23;
        shr_amt    = 10'(-s1_sh_q);
`ifdef FPXX_TO_FIXED_ROUND_EN
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
        shr_ext     = {s1_mant_q, 24'd0} >> shr_amt;
`endif
        if (s2_accept && s1_valid_q) begin
            s2_sign_d = s1_sign_q;
            s2_zero_d = s1_zero_q || s1_nan_q;
            s2_nan_d  = s1_nan_q;
            if (s1_inf_q)
                s2_ovf_d = 1'b1;
            else if (s1_zero_q || s1_nan_q)
                s2_ovf_d = 1'b0;
            else if (s1_sign_q)
                s2_ovf_d = (s2_e > LIMIT_E) || ((s2_e == LIMIT_E) && (s1_mant_q[22:0] != 23'd0));
            else
                s2_ovf_d = (s2_e >= LIMIT_E);
`ifdef FPXX_TO_FIXED_ROUND_EN
            if (!s1_sh_q[9]) begin
                s2_mag_d    = OUT_WIDTH'({{OUT_WIDTH{1'b0}}, s1_mant_q} << s1_sh_q);
                s2_guard_d  = 1'b0;
                s2_sticky_d = 1'b0;
            end else begin
                s2_mag_d    = OUT_WIDTH'(shr_ext[47:24]);
                s2_guard_d  = shr_ext[23];
                s2_sticky_d = |shr_ext[22:0];
            end
`else
            if (!s1_sh_q[9])
                s2_mag_d = OUT_WIDTH'({{OUT_WIDTH{1'b0}}, s1_mant_q} << s1_sh_q);
            else
                s2_mag_d = OUT_WIDTH'(s1_mant_q >> shr_amt);
`endif
        end
    end

    always_comb begin
`ifdef FPXX_TO_FIXED_ROUND_EN
        rmag    = {1'b0, s2_mag_q} + {{OUT_WIDTH{1'b0}}, s2_guard_q & (s2_sticky_q | s2_mag_q[0])};
        mag_fin = rmag[OUT_WIDTH-1:0];
        ovf_fin = s2_ovf_q || (!s2_zero_q &&
                  (s2_sign_q ? (rmag > {1'b0, NEG_SAT}) : (rmag > {1'b0, POS_SAT})));
`else
        mag_fin = s2_mag_q;
        ovf_fin = s2_ovf_q;
`endif
        s3_valid_d = s3_accept ? s2_valid_q : s3_valid_q;
        s3_data_d  = s3_data_q;
        s3_ovf_d   = s3_ovf_q;
        s3_nan_d   = s3_nan_q;
        if (s3_accept && s2_valid_q) begin
            s3_nan_d = s2_nan_q;
            s3_ovf_d = ovf_fin;
            if (s2_zero_q)
                s3_data_d = '0;
            else if (ovf_fin)
                s3_data_d = s2_sign_q ? NEG_SAT : POS_SAT;
            else
                s3_data_d = s2_sign_q ? -mag_fin : mag_fin;
        end
    end

    always_ff @(posedge osc_clk or negedge osc_reset_n) begin
        if (!osc_reset_n) begin
            rdy_q       <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_mant_q   <= '0;
            s1_sh_q     <= '0;
            s1_zero_q   <= 1'b0;
            s1_nan_q    <= 1'b0;
            s1_inf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_mag_q    <= '0;
            s2_ovf_q    <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_nan_q    <= 1'b0;
`ifdef FPXX_TO_FIXED_ROUND_EN
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
`endif
            s3_valid_q  <= 1'b0;
            s3_data_q   <= '0;
            s3_ovf_q    <= 1'b0;
            s3_nan_q    <= 1'b0;
        end else begin
            rdy_q       <= rdy_d;
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_mant_q   <= s1_mant_d;
            s1_sh_q     <= s1_sh_d;
            s1_zero_q   <= s1_zero_d;
            s1_nan_q    <= s1_nan_d;
            s1_inf_q    <= s1_inf_d;
            s2_valid_q  <= s2_valid_d;
            s2_sign_q   <= s2_sign_d;
            s2_mag_q    <= s2_mag_d;
            s2_ovf_q    <= s2_ovf_d;
            s2_zero_q   <= s2_zero_d;
            s2_nan_q    <= s2_nan_d;
`ifdef FPXX_TO_FIXED_ROUND_EN
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
`endif
            s3_valid_q  <= s3_valid_d;
            s3_data_q   <= s3_data_d;
            s3_ovf_q    <= s3_ovf_d;
            s3_nan_q    <= s3_nan_d;
        end
    end

    assign bus.in_ready  = rdy_q && s1_accept;
    assign bus.out_valid = s3_valid_q;
    assign bus.out_data  = s3_data_q;
    assign bus.out_ovf   = s3_ovf_q;
    assign bus.out_nan   = s3_nan_q;

endmodule

// File: tb/tb_fpxx_to_fixed.sv
// Scoreboard bench for fpxx_to_fixed: directed fp32 vectors, backpressure and mid-stream reset.
// Expected values follow FPXX_TO_FIXED_ROUND_EN when it is defined.
module tb_fpxx_to_fixed;

    localparam int OUT_WIDTH = 32;
    localparam int FRAC_BITS = 8;

    typedef struct {
        logic [31:0] word;
        logic [31:0] data;
        logic        ovf;
        logic        nan;
    } exp_t;

    logic osc_clk     = 1'b0;
    logic osc_reset_n = 1'b0;
    int   total       = 0;
    int   bad         = 0;
    int   cyc         = 0;
    int   last_accept = 0;
    exp_t sb_q[$];

    always #5 osc_clk = ~osc_clk;

    fpxx_to_fixed_if #(.OUT_WIDTH(OUT_WIDTH)) bus ();

    fpxx_to_fixed #(
        .OUT_WIDTH(OUT_WIDTH),
        .FRAC_BITS(FRAC_BITS)
    ) dut (
        .osc_clk    (osc_clk),
        .osc_reset_n(osc_reset_n),
        .bus        (bus)
    );

    initial forever begin
        @(posedge osc_clk);
        cyc++;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic fail_timeout(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: timed out, expected event did not occur", name);
    endtask

    // Offer one word; the expected result is queued at the moment it is accepted.
    task automatic applyStimulus(input logic [31:0] word, input logic [31:0] e_data,
                                 input logic e_ovf, input logic e_nan);
        int waits = 0;
        exp_t e;
        @(negedge osc_clk);
        bus.in_valid = 1'b1;
        bus.in_data  = word;
        while (!bus.in_ready && waits < 50) begin
            @(negedge osc_clk);
            waits++;
        end
        if (!bus.in_ready) begin
            fail_timeout($sformatf("accept of %h", word));
            bus.in_valid = 1'b0;
            return;
        end
        e.word = word;
        e.data = e_data;
        e.ovf  = e_ovf;
        e.nan  = e_nan;
        sb_q.push_back(e);
        last_accept = cyc;
        @(posedge osc_clk);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge osc_clk);
            n++;
        end
        if (sb_q.size() != 0) fail_timeout("scoreboard drain");
    endtask

    // Monitor: pops on every output transfer and checks held outputs stay put while stalled.
    initial begin
        logic        held;
        logic [31:0] held_data;
        logic        held_ovf, held_nan;
        exp_t        e;
        held = 1'b0;
        held_data = '0;
        held_ovf = 1'b0;
        held_nan = 1'b0;
        forever begin
            @(negedge osc_clk);
            if (!osc_reset_n) begin
                held = 1'b0;
            end else begin
                if (held && bus.out_valid) begin
                    checkOutput("stall hold data", 64'(bus.out_data), 64'(held_data));
                    checkOutput("stall hold ovf", 64'(bus.out_ovf), 64'(held_ovf));
                    checkOutput("stall hold nan", 64'(bus.out_nan), 64'(held_nan));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected output: got 0x%0h, expected none", bus.out_data);
                    end else begin
                        e = sb_q.pop_front();
                        checkOutput($sformatf("data for %h", e.word), 64'(bus.out_data), 64'(e.data));
                        checkOutput($sformatf("ovf for %h", e.word), 64'(bus.out_ovf), 64'(e.ovf));
                        checkOutput($sformatf("nan for %h", e.word), 64'(bus.out_nan), 64'(e.nan));
                    end
                end
                held      = bus.out_valid && !bus.out_ready;
                held_data = bus.out_data;
                held_ovf  = bus.out_ovf;
                held_nan  = bus.out_nan;
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int lat;
        bit seen;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;

        repeat (2) @(negedge osc_clk);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset out_data", 64'(bus.out_data), 64'd0);
        checkOutput("reset out_ovf", 64'(bus.out_ovf), 64'd0);
        checkOutput("reset out_nan", 64'(bus.out_nan), 64'd0);
        osc_reset_n = 1'b1;
        @(negedge osc_clk);
        checkOutput("in_ready after reset", 64'(bus.in_ready), 64'd1);

        $display("[TB] latency and basic values");
        applyStimulus(32'h3F800000, 32'h00000100, 1'b0, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge osc_clk);
            seen = bus.out_valid;
        end
        if (!seen) fail_timeout("first output");
        else begin
            lat = cyc - last_accept;
            checkOutput("latency", 64'(lat), 64'd3);
        end

        applyStimulus(32'hBFC00000, 32'hFFFFFE80, 1'b0, 1'b0);
        applyStimulus(32'hBB800000, 32'hFFFFFFFF, 1'b0, 1'b0);
        applyStimulus(32'h3F808000, 32'h00000101, 1'b0, 1'b0);
        applyStimulus(32'h3F800080, 32'h00000100, 1'b0, 1'b0);
        applyStimulus(32'h3F804000, 32'h00000100, 1'b0, 1'b0);
`ifdef FPXX_TO_FIXED_ROUND_EN
        applyStimulus(32'h3F80C000, 32'h00000102, 1'b0, 1'b0);
`else
        applyStimulus(32'h3F80C000, 32'h00000101, 1'b0, 1'b0);
`endif
        applyStimulus(32'h00000000, 32'h00000000, 1'b0, 1'b0);
        applyStimulus(32'h80000000, 32'h00000000, 1'b0, 1'b0);
        applyStimulus(32'h00000001, 32'h00000000, 1'b0, 1'b0);
        applyStimulus(32'h7FC00000, 32'h00000000, 1'b0, 1'b1);
        applyStimulus(32'hFFC00000, 32'h00000000, 1'b0, 1'b1);
        applyStimulus(32'h7F800000, 32'h7FFFFFFF, 1'b1, 1'b0);
        applyStimulus(32'hFF800000, 32'h80000000, 1'b1, 1'b0);
        applyStimulus(32'h4B000000, 32'h7FFFFFFF, 1'b1, 1'b0);
        applyStimulus(32'hCB000000, 32'h80000000, 1'b0, 1'b0);
        applyStimulus(32'h4AFFFFFE, 32'h7FFFFF00, 1'b0, 1'b0);
        wait_drain();

        $display("[TB] backpressure stream");
        fork
            begin
                applyStimulus(32'h3F800000, 32'h00000100, 1'b0, 1'b0);
                applyStimulus(32'h40000000, 32'h00000200, 1'b0, 1'b0);
                applyStimulus(32'h40400000, 32'h00000300, 1'b0, 1'b0);
                applyStimulus(32'h40800000, 32'h00000400, 1'b0, 1'b0);
                applyStimulus(32'h40A00000, 32'h00000500, 1'b0, 1'b0);
                applyStimulus(32'h40C00000, 32'h00000600, 1'b0, 1'b0);
            end
            begin
                bit got;
                got = 1'b0;
                for (int k = 0; k < 20 && !got; k++) begin
                    @(posedge osc_clk);
                    #1 got = bus.out_valid;
                end
                if (!got) fail_timeout("backpressure first output");
                bus.out_ready = 1'b0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge osc_clk);
                    checkOutput($sformatf("in_ready stalled %0d", k), 64'(bus.in_ready), 64'd0);
                end
                @(posedge osc_clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("[TB] reset mid-stream");
        @(posedge osc_clk);
        #1 bus.out_ready = 1'b0;
        applyStimulus(32'h40000000, 32'h00000200, 1'b0, 1'b0);
        applyStimulus(32'h40400000, 32'h00000300, 1'b0, 1'b0);
        applyStimulus(32'h40800000, 32'h00000400, 1'b0, 1'b0);
        repeat (2) @(negedge osc_clk);
        #2 osc_reset_n = 1'b0;
        sb_q.delete();
        #1 checkOutput("out_valid in reset", 64'(bus.out_valid), 64'd0);
        repeat (2) @(negedge osc_clk);
        osc_reset_n = 1'b1;
        @(posedge osc_clk);
        #1 bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge osc_clk);
            checkOutput($sformatf("no stale output %0d", k), 64'(bus.out_valid), 64'd0);
        end
        applyStimulus(32'hBFC00000, 32'hFFFFFE80, 1'b0, 1'b0);
        wait_drain();

        repeat (3) @(negedge osc_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
